gray_sync_decode: RTL
=====================

// Module: gray_sync_decode
// PURPOSE
//  Receive side of a Gray-coded counter crossing into the clk domain, e.g. an async FIFO
//  pointer or an event counter.
//  Synchronises the N-bit Gray input through a flop chain and decodes it to binary.
//  Reports the count advance since the previous sample and flags illegal multi-bit steps.
//  Sits in the destination domain, downstream of a gray_count instance in the source domain.
// PARAMETERS
//  N            8  counter width in bits (>=2)
//  SYNC_STAGES  2  synchroniser depth in flops (>=2)
// PORTS
//  clk        in   1  destination clock
//  reset      in   1  asynchronous, active-high reset
//  enable     in   1  sample enable; capture occurs only when high
//  gray_in    in   N  Gray count from the source domain (asynchronous)
//  bin_out    out  N  decoded binary value of the last capture
//  bin_valid  out  1  sticky; high once the first capture after reset has occurred
//  delta      out  N  (bin_new - bin_prev) mod 2^N at the last capture
//  step_err   out  1  one-cycle pulse: illegal Gray step between back-to-back captures
//  err_count  out  8  saturating step_err counter; present only with GRAY_SYNC_ERRCNT_EN
// BEHAVIOUR
//  - Clock and reset: clk is the clock. reset is asynchronous and active-high. On reset:
//    - all sync flops, bin_out, delta, step_err, bin_valid and err_count clear to 0;
//    - the gray_prev register and the fill counter clear to 0.
//  - Sync chain: free-running every clk edge, independent of enable. g_s is its last stage.
//  - Fill counter: counts clk edges after reset release, saturating at SYNC_STAGES.
//    - filled = (fill == SYNC_STAGES).
//  - Capture: occurs on a clk edge where enable && filled.
//  - Decode is combinational from g_s:
//    - b[N-1] = g_s[N-1];
//    - b[i] = b[i+1] ^ g_s[i].
//  - On capture:
//    - bin_out <= b; gray_prev <= g_s; bin_valid <= 1.
//    - delta <= bin_valid ? (b - bin_out) mod 2^N : 0. A first capture always gives delta 0.
//  - Without capture: bin_out, delta and gray_prev hold.
//  - Latency: a stable gray_in change appears on bin_out SYNC_STAGES+1 edges later, with
//    enable held high.
//  - step_err:
//    - Asserts for exactly one cycle when a capture occurs, the previous cycle was also a
//      capture, bin_valid is already 1, and popcount(g_s ^ gray_prev) > 1.
//    - Otherwise step_err is 0.
//    - Zero-bit and one-bit changes are legal.
//    - Captures separated by enable-low gaps are never checked; multi-step advances are legal.
//  - Wrap-around: Gray 100..0 -> 000..0 (binary 2^N-1 -> 0) is a legal single-bit step.
//    It gives delta = 1 and no step_err.
//  - Reset mid-operation: outputs clear immediately, bin_valid drops, and the fill counter
//    restarts. The first post-reset capture gives delta 0.
//  - Simultaneous events: enable rising in the same edge that filled becomes true does not
//    capture. Capture requires filled to be true before that edge.
// CONFIGURATION
//  - GRAY_SYNC_ERRCNT_EN defined:
//    - the err_count port exists;
//    - it increments on every step_err pulse, saturates at 255, and clears only on reset.
//  - GRAY_SYNC_ERRCNT_EN undefined:
//    - the err_count port and its logic are absent;
//    - all other behaviour is identical.
// TESTING (N=8, SYNC_STAGES=2)
//  1. Reset pulse, gray_in=0x00, enable=1
//     -> bin_valid=0 for 2 edges after release; rises on 3rd edge; bin_out=0x00, delta=0.
//  2. Drive gray_in = binary-to-Gray of 0..255, one per clk
//     -> bin_out lags by 3 edges; delta=1 every capture after the first; step_err never high.
//  3. gray_in 0x80 -> 0x00 on consecutive cycles
//     -> bin_out 0xFF -> 0x00, delta=1, step_err=0.
//  4. gray_in 0x00 -> 0x03 (binary 0 -> 2) on consecutive captures
//     -> delta=2, step_err high one cycle, err_count=1 (macro on).
//  5. enable=0 for 4 cycles while the source advances 4 steps, then enable=1
//     -> delta=4, step_err=0.
//  6. Assert reset mid-stream with bin_out=0x37
//     -> bin_out, delta, bin_valid and err_count read 0 before the next clk edge; sequence
//        restarts as in test 1.

Source files
------------

// File: rtl/gray_sync_decode_if.sv
// Bus bundle for gray_sync_decode: sampling controls in, decoded count and step status out.
// err_count is present only with GRAY_SYNC_ERRCNT_EN defined.
interface gray_sync_decode_if #(
  parameter int N = 8
);
  logic         enable;
  logic [N-1:0] gray_in;
  logic [N-1:0] bin_out;
  logic         bin_valid;
  logic [N-1:0] delta;
  logic         step_err;
`ifdef GRAY_SYNC_ERRCNT_EN
  logic [7:0]   err_count;
`endif

  modport master (
    output enable, gray_in,
`ifdef GRAY_SYNC_ERRCNT_EN
    input  err_count,
`endif
    input  bin_out, bin_valid, delta, step_err
  );

  modport slave (
    input  enable, gray_in,
`ifdef GRAY_SYNC_ERRCNT_EN
    output err_count,
`endif
    output bin_out, bin_valid, delta, step_err
  );
endinterface

// File: rtl/gray_sync_decode.sv
// Synchronises a Gray count into clk, decodes to binary, reports advance and illegal steps.
// Latency SYNC_STAGES+1 edges; no backpressure (enable gates capture only); GRAY_SYNC_ERRCNT_EN adds err_count.
module gray_sync_decode #(
  parameter int N           = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic               clk,
  input logic               reset,
  gray_sync_decode_if.slave bus
);
  localparam int FW = $clog2(SYNC_STAGES + 1);

  logic [N-1:0]  sync_q [SYNC_STAGES];
  logic [FW-1:0] fill;
  logic          filled;
  logic          capture;
  logic          prev_cap;
  logic [N-1:0]  g_s;
  logic [N-1:0]  b;
  logic [N-1:0]  gray_prev;
  logic [N-1:0]  gray_diff;
  logic          multi_bit;
  logic          step_det;

  assign g_s       = sync_q[SYNC_STAGES-1];
  assign filled    = (fill == FW'(SYNC_STAGES));
  assign capture   = bus.enable && filled;
  assign gray_diff = g_s ^ gray_prev;
  // More than one bit set iff clearing the lowest set bit leaves something behind.
  assign multi_bit = (gray_diff & (gray_diff - N'(1))) != '0;
  assign step_det  = capture && prev_cap && bus.bin_valid && multi_bit;

  // Binary bit i is the XOR of all Gray bits at or above i.
  always_comb begin
    b = '0;
    for (int i = 0; i < N; i++) begin
      b[i] = ^(g_s >> i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      fill <= '0;
    end else begin
      sync_q[0] <= bus.gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      if (!filled) begin
        fill <= fill + FW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.bin_out   <= '0;
      bus.bin_valid <= 1'b0;
      bus.delta     <= '0;
      bus.step_err  <= 1'b0;
      gray_prev     <= '0;
      prev_cap      <= 1'b0;
    end else begin
      prev_cap     <= capture;
      bus.step_err <= step_det;
      if (capture) begin
        bus.bin_out   <= b;
        gray_prev     <= g_s;
        bus.bin_valid <= 1'b1;
        bus.delta     <= bus.bin_valid ? (b - bus.bin_out) : '0;
      end
    end
  end

`ifdef GRAY_SYNC_ERRCNT_EN
  // Counts alongside the step_err pulse so both become visible on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.err_count <= '0;
    end else if (step_det && (bus.err_count != 8'hFF)) begin
      bus.err_count <= bus.err_count + 8'd1;
    end
  end
`endif
endmodule
